// File: rtl/gshare_pkg.sv
// Shared types and counter helpers for the gshare predictor.
// Combinational functions only; no state lives here.
// No flow control; consumers call these from their own logic.
package gshare_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Widest counter any instance may use; helpers work at this width.
  localparam int unsigned CTR_MAX_W = 4;
  typedef logic [CTR_MAX_W-1:0] ctr_t;

  // Weakly-not-taken value, just below the taken threshold.
  function automatic ctr_t ctr_init(input int unsigned ctr_w);
    return ctr_t'((1 << (ctr_w - 1)) - 1);
  endfunction

  // Saturating step towards the resolved direction.
  function automatic ctr_t ctr_next(input ctr_t ctr, input logic taken,
                                    input int unsigned ctr_w);
    ctr_t top;
    top = ctr_t'((1 << ctr_w) - 1);
    if (taken) begin
      return (ctr == top) ? ctr : ctr + 1'b1;
    end
    return (ctr == '0) ? ctr : ctr - 1'b1;
  endfunction

endpackage

// File: rtl/gshare_pht.sv
// Pattern history table: 2^IDX_W saturating counters, one read and one write port.
// Read is combinational; writes land on the next rising edge.
// No backpressure; an init write wins over a training update.
module gshare_pht
  import gshare_pkg::*;
#(
  parameter int unsigned IDX_W = 7,
  parameter int unsigned CTR_W = 2
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [CTR_W-1:0] rd_ctr,
  input  logic             init_en,
  input  logic [IDX_W-1:0] init_idx,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  localparam int unsigned DEPTH = 1 << IDX_W;
  localparam logic [CTR_W-1:0] WNT = CTR_W'(ctr_init(CTR_W));

  // Contents are defined by the init sweep, so the array carries no reset.
  logic [CTR_W-1:0] pht_q [DEPTH];
  logic [CTR_W-1:0] upd_nxt;

  // Prediction read; sees the pre-update value on a same-index write.
  assign rd_ctr = pht_q[rd_idx];

  // Read-modify-write value for the training port.
  assign upd_nxt = CTR_W'(ctr_next(ctr_t'(pht_q[upd_idx]), upd_taken, CTR_W));

  // Single write port: sweep writes have priority over training.
  always_ff @(posedge clk) begin
    if (init_en) begin
      pht_q[init_idx] <= WNT;
    end else if (upd_en) begin
      pht_q[upd_idx] <= upd_nxt;
    end
  end

endmodule

// File: rtl/gshare_predictor_param.sv
// Gshare direction predictor: history XOR PC indexes a saturating-counter table.
// Prediction is combinational; table/history updates take effect next edge; init sweep 2^IDX_W cycles.
// ready is low during the sweep and all requests are dropped; no other backpressure.
module gshare_predictor_param
  import gshare_pkg::*;
#(
  parameter int unsigned IDX_W  = 7,
  parameter int unsigned HIST_W = 7,
  parameter int unsigned PC_W   = 7,
  parameter int unsigned CTR_W  = 2
) (
  input  logic              clk,
  input  logic              areset_n,
  input  logic              flush,
  output logic              ready,
  input  logic              predict_valid,
  input  logic [PC_W-1:0]   predict_pc,
  output logic              predict_taken,
  output logic [HIST_W-1:0] predict_history,
  input  logic              train_valid,
  input  logic              train_taken,
  input  logic              train_mispredicted,
  input  logic [HIST_W-1:0] train_history,
  input  logic [PC_W-1:0]   train_pc
);

  localparam logic [IDX_W-1:0] LAST_IDX = '1;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [HIST_W-1:0] hist_q, hist_d;

  logic              run;
  logic              init_en;
  logic              upd_en;
  logic [IDX_W-1:0]  pred_idx;
  logic [IDX_W-1:0]  train_idx;
  logic [CTR_W-1:0]  pred_ctr;

  assign run = (state_q == RUN);

  // Index hashing: short histories are zero-extended to the index width.
  assign pred_idx  = predict_pc[IDX_W-1:0] ^ IDX_W'(hist_q);
  assign train_idx = train_pc[IDX_W-1:0]   ^ IDX_W'(train_history);

  // A flush cycle neither sweeps nor trains; the sweep restarts from 0 next cycle.
  assign init_en = (state_q == INIT) && !flush;
  assign upd_en  = run && train_valid && !flush;

  assign ready           = run;
  assign predict_taken   = run && predict_valid && pred_ctr[CTR_W-1];
  assign predict_history = (run && predict_valid) ? hist_q : '0;

  gshare_pht #(
    .IDX_W (IDX_W),
    .CTR_W (CTR_W)
  ) u_pht (
    .clk       (clk),
    .rd_idx    (pred_idx),
    .rd_ctr    (pred_ctr),
    .init_en   (init_en),
    .init_idx  (ptr_q),
    .upd_en    (upd_en),
    .upd_idx   (train_idx),
    .upd_taken (train_taken)
  );

  // Next state: sweep progress, flush restart, and history shift/repair.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hist_d  = hist_q;
    case (state_q)
      INIT: begin
        if (flush) begin
          ptr_d  = '0;
          hist_d = '0;
        end else begin
          ptr_d = ptr_q + 1'b1;
          if (ptr_q == LAST_IDX) begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (flush) begin
          state_d = INIT;
          ptr_d   = '0;
          hist_d  = '0;
        end else if (train_valid && train_mispredicted) begin
          // Repair from the resolved branch; overrides any speculative shift.
          hist_d = HIST_W'({train_history, train_taken});
        end else if (predict_valid) begin
          hist_d = HIST_W'({hist_q, predict_taken});
        end
      end
      default: begin
        state_d = INIT;
        ptr_d   = '0;
        hist_d  = '0;
      end
    endcase
  end

  // State, sweep pointer and history registers.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q <= INIT;
      ptr_q   <= '0;
      hist_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hist_q  <= hist_d;
    end
  end

endmodule
